// File: rtl/fp8_vector_mul_pipe.sv
// Purpose: scales four FP8 vector elements by one shared FP8 operand, giving IEEE binary16 products.
// Latency: 2 clk (stage 1 decode + significand product, stage 2 normalize/round/pack).
// Backpressure: none; one vector per cycle, in_valid shifts straight through to out_valid.
//
// Ports: clk, rst (async, active low) | e5m2mode selects E5M2 (1) or E4M3 (0) for all operands |
//        in_valid, q, a..d operand inputs | out_valid, qa..qd binary16 results (q*a .. q*d).
module fp8_vector_mul_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        e5m2mode,
    input  logic        in_valid,
    input  logic [7:0]  q,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic [7:0]  c,
    input  logic [7:0]  d,
    output logic [15:0] qa,
    output logic [15:0] qb,
    output logic [15:0] qc,
    output logic [15:0] qd,
    output logic        out_valid
);

    // One decoded FP8 operand. Both formats are mapped onto a 4-bit integer
    // significand and an effective exponent (subnormals use exponent 1 with
    // the hidden bit cleared), so the product path is format independent.
    typedef struct packed {
        logic       sign;
        logic [3:0] mant;
        logic [4:0] eeff;
        logic       zero;
        logic       inf;
        logic       nan;
    } dec_t;

    typedef enum logic [1:0] {
        CLS_FIN  = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_INF  = 2'd2,
        CLS_NAN  = 2'd3
    } cls_e;

    // Stage-1 record: the finite product is exactly prod * 2^lsb_exp,
    // lsb_exp being a two's complement exponent of the product's LSB.
    typedef struct packed {
        logic       sign;
        cls_e       cls;
        logic [7:0] prod;
        logic [7:0] lsb_exp;
    } s1_t;

    function automatic dec_t decode(input logic [7:0] x, input logic m5);
        dec_t r;
        r      = '0;
        r.sign = x[7];
        if (m5) begin
            r.eeff = (x[6:2] == 5'd0) ? 5'd1 : x[6:2];
            r.mant = {1'b0, x[6:2] != 5'd0, x[1:0]};
            r.inf  = (x[6:2] == 5'd31) && (x[1:0] == 2'd0);
            r.nan  = (x[6:2] == 5'd31) && (x[1:0] != 2'd0);
            r.zero = (x[6:0] == 7'd0);
        end else begin
            r.eeff = {1'b0, (x[6:3] == 4'd0) ? 4'd1 : x[6:3]};
            r.mant = {x[6:3] != 4'd0, x[2:0]};
            r.inf  = 1'b0;
            r.nan  = (x[6:0] == 7'h7F);
            r.zero = (x[6:0] == 7'd0);
        end
        return r;
    endfunction

    function automatic s1_t stage1(input logic [7:0] x, input logic [7:0] y, input logic m5);
        dec_t dx;
        dec_t dy;
        s1_t  r;
        dx        = decode(x, m5);
        dy        = decode(y, m5);
        r         = '0;
        r.sign    = dx.sign ^ dy.sign;
        r.prod    = {4'd0, dx.mant} * {4'd0, dy.mant};
        // Remove both biases and both fraction widths: E4M3 2*7+2*3, E5M2 2*15+2*2.
        r.lsb_exp = {3'd0, dx.eeff} + {3'd0, dy.eeff} - (m5 ? 8'd34 : 8'd20);
        if (dx.nan || dy.nan || (dx.inf && dy.zero) || (dy.inf && dx.zero))
            r.cls = CLS_NAN;
        else if (dx.inf || dy.inf)
            r.cls = CLS_INF;
        else if (dx.zero || dy.zero)
            r.cls = CLS_ZERO;
        else
            r.cls = CLS_FIN;
        return r;
    endfunction

    function automatic logic [15:0] stage2(input s1_t r);
        logic [15:0]       res;
        logic [2:0]        lead;
        logic signed [8:0] e_top;
        logic signed [8:0] shamt;
        logic [3:0]        rs;
        logic [7:0]        qv;
        logic [7:0]        rem;
        logic [7:0]        half;
        logic [10:0]       mag;
        logic              up;
        res   = 16'h0000;
        lead  = 3'd0;
        rs    = 4'd0;
        qv    = 8'd0;
        rem   = 8'd0;
        half  = 8'd0;
        mag   = 11'd0;
        up    = 1'b0;
        for (int i = 0; i < 8; i++)
            if (r.prod[i]) lead = 3'(i);
        e_top = $signed({r.lsb_exp[7], r.lsb_exp}) + $signed({6'd0, lead});
        shamt = $signed({r.lsb_exp[7], r.lsb_exp}) + 9'sd24;
        case (r.cls)
            CLS_NAN:  res = 16'h7E00;
            CLS_INF:  res = {r.sign, 15'h7C00};
            CLS_ZERO: res = {r.sign, 15'h0000};
            default: begin
                if (e_top >= -9'sd14) begin
                    // Normal result: at most 8 significant bits, so always exact.
                    if (e_top > 9'sd15)
                        res = {r.sign, 15'h7C00};
                    else
                        res = {r.sign, 5'(e_top + 9'sd15),
                               10'({2'd0, r.prod} << (4'd10 - {1'b0, lead}))};
                end else begin
                    // Subnormal result, expressed in units of 2^-24. Only E5M2
                    // can land below 2^-24 and needs rounding; a round-up to
                    // 1024 carries naturally into the smallest normal encoding.
                    if (shamt >= 9'sd0) begin
                        mag = 11'({3'd0, r.prod} << 4'(shamt));
                    end else begin
                        rs   = 4'(-shamt);
                        qv   = r.prod >> rs;
                        rem  = r.prod & ((8'd1 << rs) - 8'd1);
                        half = 8'd1 << (rs - 4'd1);
                        up   = (rem > half) || ((rem == half) && qv[0]);
                        mag  = {3'd0, qv} + {10'd0, up};
                    end
                    res = {r.sign, 4'd0, mag};
                end
            end
        endcase
        return res;
    endfunction

    logic [7:0]  elem [4];
    s1_t         s1_d [4];
    s1_t         s1_q [4];
    logic [15:0] res_q [4];
    logic        vld_s1;

    assign elem[0] = a;
    assign elem[1] = b;
    assign elem[2] = c;
    assign elem[3] = d;

    always_comb begin
        for (int i = 0; i < 4; i++)
            s1_d[i] = stage1(q, elem[i], e5m2mode);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_s1    <= 1'b0;
            out_valid <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                s1_q[i]  <= '0;
                res_q[i] <= 16'h0000;
            end
        end else begin
            vld_s1    <= in_valid;
            out_valid <= vld_s1;
            for (int i = 0; i < 4; i++) begin
                s1_q[i]  <= s1_d[i];
                res_q[i] <= stage2(s1_q[i]);
            end
        end
    end

    assign qa = res_q[0];
    assign qb = res_q[1];
    assign qc = res_q[2];
    assign qd = res_q[3];

endmodule

// File: tb/tb_fp8_vector_mul_pipe.sv
// Purpose: self-checking bench for fp8_vector_mul_pipe against a real-arithmetic reference.
// Latency: expects results and out_valid two clk edges after each input.
// Backpressure: none; inputs applied every cycle, outputs sampled 1 time unit after each edge.
module tb_fp8_vector_mul_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        e5m2mode;
    logic        in_valid;
    logic [7:0]  q, a, b, c, d;
    logic [15:0] qa, qb, qc, qd;
    logic        out_valid;

    always #5 clk = ~clk;

    fp8_vector_mul_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .e5m2mode  (e5m2mode),
        .in_valid  (in_valid),
        .q         (q),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .qa        (qa),
        .qb        (qb),
        .qc        (qc),
        .qd        (qd),
        .out_valid (out_valid)
    );

    typedef struct packed {
        logic             vld;
        logic [3:0][15:0] e;
    } exp_t;

    exp_t prev;
    exp_t cur;
    int   n_vec    = 0;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   ov_cnt   = 0;
    bit   counting = 1'b0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r * 0.5;
        return r;
    endfunction

    // Magnitude of an FP8 value; NaN/Inf flagged separately.
    function automatic void fp8_val(input logic [7:0] x, input logic m5,
                                    output real mag, output bit is_nan, output bit is_inf);
        int e, f;
        mag = 0.0; is_nan = 0; is_inf = 0;
        if (!m5) begin
            e = int'(x[6:3]); f = int'(x[2:0]);
            if (x[6:0] == 7'h7F) is_nan = 1;
            else if (e == 0)     mag = (f / 8.0) * pow2(-6);
            else                 mag = (1.0 + f / 8.0) * pow2(e - 7);
        end else begin
            e = int'(x[6:2]); f = int'(x[1:0]);
            if (e == 31) begin is_inf = (f == 0); is_nan = (f != 0); end
            else if (e == 0) mag = (f / 4.0) * pow2(-14);
            else             mag = (1.0 + f / 4.0) * pow2(e - 15);
        end
    endfunction

    function automatic int rne(input real u);
        int  n;
        real fr;
        n  = int'($floor(u));
        fr = u - n;
        if (fr > 0.5 || (fr == 0.5 && (n % 2) == 1)) n++;
        return n;
    endfunction

    function automatic logic [15:0] enc16(input bit s, input real mag);
        int e, n;
        if (mag == 0.0)      return {s, 15'h0000};
        if (mag >= 65520.0)  return {s, 15'h7C00};
        if (mag < pow2(-14)) begin
            n = rne(mag * pow2(24));
            return {s, 15'(n)};
        end
        e = 15;
        while (mag < pow2(e)) e--;
        n = rne(mag * pow2(10 - e));
        if (n == 2048) begin n = 1024; e++; end
        if (e > 15) return {s, 15'h7C00};
        return {s, 5'(e + 15), 10'(n - 1024)};
    endfunction

    function automatic logic [15:0] ref_mul(input logic m5, input logic [7:0] x, input logic [7:0] y);
        real mx, my;
        bit  nx, ny, ix, iy, zx, zy, s;
        fp8_val(x, m5, mx, nx, ix);
        fp8_val(y, m5, my, ny, iy);
        s  = x[7] ^ y[7];
        zx = !nx && !ix && (mx == 0.0);
        zy = !ny && !iy && (my == 0.0);
        if (nx || ny || (ix && zy) || (iy && zx)) return 16'h7E00;
        if (ix || iy)                             return {s, 15'h7C00};
        return enc16(s, mx * my);
    endfunction

    // Apply one input cycle, then check what the DUT shows after that edge
    // against the entry applied one cycle earlier.
    task automatic step(input logic v, input logic m5,
                        input logic [7:0] qq, input logic [7:0] aa, input logic [7:0] bb,
                        input logic [7:0] cc, input logic [7:0] dd,
                        input bit fixed, input logic [15:0] f0, input logic [15:0] f1,
                        input logic [15:0] f2, input logic [15:0] f3);
        in_valid = v; e5m2mode = m5; q = qq; a = aa; b = bb; c = cc; d = dd;
        cur.vld = v;
        if (fixed) begin
            cur.e[0] = f0; cur.e[1] = f1; cur.e[2] = f2; cur.e[3] = f3;
        end else begin
            cur.e[0] = ref_mul(m5, qq, aa);
            cur.e[1] = ref_mul(m5, qq, bb);
            cur.e[2] = ref_mul(m5, qq, cc);
            cur.e[3] = ref_mul(m5, qq, dd);
        end
        if (v) n_vec++;
        @(posedge clk);
        #1;
        check("out_valid", {15'd0, out_valid}, {15'd0, prev.vld});
        if (prev.vld) begin
            check("qa", qa, prev.e[0]);
            check("qb", qb, prev.e[1]);
            check("qc", qc, prev.e[2]);
            check("qd", qd, prev.e[3]);
        end
        if (counting && out_valid) ov_cnt++;
        prev = cur;
    endtask

    task automatic rand_step(input logic v);
        step(v, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 8'($urandom),
             8'($urandom), 8'($urandom), 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_vld"}, {15'd0, out_valid}, 16'h0000);
        check({tag, "_qa"}, qa, 16'h0000);
        check({tag, "_qb"}, qb, 16'h0000);
        check({tag, "_qc"}, qc, 16'h0000);
        check({tag, "_qd"}, qd, 16'h0000);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; e5m2mode = 1'b0;
        q = 8'h00; a = 8'h00; b = 8'h00; c = 8'h00; d = 8'h00;
        prev = '0; cur = '0;
        #12;
        check_zero_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Directed vectors with hand-derived results.
        step(1, 0, 8'h38, 8'h4C, 8'hC4, 8'h40, 8'hC8, 1, 16'h4600, 16'hC200, 16'h4000, 16'hC400);
        step(1, 0, 8'h3C, 8'h3C, 8'hC4, 8'h40, 8'hC8, 1, 16'h4080, 16'hC480, 16'h4200, 16'hC600);
        step(1, 0, 8'hC0, 8'h3C, 8'hC4, 8'h40, 8'hC8, 1, 16'hC200, 16'h4600, 16'hC400, 16'h4800);
        step(1, 0, 8'hBC, 8'h3C, 8'hC4, 8'h40, 8'hC8, 1, 16'hC080, 16'h4480, 16'hC200, 16'h4600);
        step(1, 0, 8'h7E, 8'h7E, 8'h00, 8'h80, 8'h7F, 1, 16'h7C00, 16'h0000, 16'h8000, 16'h7E00);
        step(1, 0, 8'h38, 8'h7F, 8'h80, 8'h38, 8'h01, 1, 16'h7E00, 16'h8000, 16'h3C00, 16'h1800);
        step(1, 1, 8'h7C, 8'h00, 8'h3C, 8'hBC, 8'h7F, 1, 16'h7E00, 16'h7C00, 16'hFC00, 16'h7E00);
        step(1, 1, 8'h04, 8'h04, 8'h3C, 8'h7B, 8'h2C, 1, 16'h0000, 16'h0400, 16'h4300, 16'h0040);
        step(1, 1, 8'h07, 8'h1F, 8'h3C, 8'h00, 8'h80, 1, 16'h000C, 16'h0700, 16'h0000, 16'h8000);
        idle_step();
        idle_step();

        // Random traffic with gaps, both formats.
        repeat (400) rand_step(1'($urandom_range(0, 3) != 0));
        repeat (3) idle_step();

        // Back-to-back burst of 8 followed by idle.
        counting = 1'b1;
        repeat (8) rand_step(1'b1);
        repeat (4) idle_step();
        counting = 1'b0;
        check("burst_count", 16'(ov_cnt), 16'd8);

        // Reset with two vectors in flight.
        rand_step(1'b1);
        rand_step(1'b1);
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_zero_outputs("inflight_rst");
        @(posedge clk); #1;
        check_zero_outputs("held_rst");
        rst = 1'b1;
        prev = '0;
        repeat (4) idle_step();
        rand_step(1'b1);
        repeat (3) idle_step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
